// File: rtl/ud_cmd_gen.sv
// Up/down counter command generator: synchronises and debounces three raw
// buttons, then issues single-cycle ld/incr/decr pulses with hold-to-repeat
// and optional saturation against the counter readback.

// Per-button synchroniser + debouncer.
module ud_cmd_deb #(
   parameter int DEB_CYC = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level
);
   localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

   logic          s1, s2;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Level flips only after DEB_CYC consecutive mismatching samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (s2 != level) begin
         if (cnt == CW'(DEB_CYC - 1)) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end
endmodule

module ud_cmd_gen #(
   parameter int SIZE    = 5,
   parameter int DEB_CYC = 4,
   parameter int RPT_DLY = 16,
   parameter int RPT_PER = 4,
   parameter int SAT     = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            btn_up,
   input  logic            btn_dn,
   input  logic            btn_ld,
   input  logic [SIZE-1:0] base_in,
   input  logic [SIZE-1:0] cur_count,
   output logic            incr,
   output logic            decr,
   output logic            ld,
   output logic [SIZE-1:0] D
);
   localparam int TMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
   localparam int TW   = $clog2(TMAX);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   logic [2:0]    raw, deb;
   logic          deb_up, deb_dn, deb_ld;
   logic          ld_prev;
   state_t        state;
   logic          dir;        // 1 = up, 0 = down
   logic [TW-1:0] timer;
   logic [TW-1:0] lim;
   logic          sat_hi, sat_lo, abort;

   assign raw = {btn_ld, btn_dn, btn_up};

   for (genvar g = 0; g < 3; g++) begin : g_deb
      ud_cmd_deb #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (raw[g]),
         .level   (deb[g])
      );
   end

   assign deb_up = deb[0];
   assign deb_dn = deb[1];
   assign deb_ld = deb[2];

   // Saturation masks use the readback sampled in the pulse-generating cycle.
   assign sat_hi = (SAT != 0) && (cur_count == {SIZE{1'b1}});
   assign sat_lo = (SAT != 0) && (cur_count == '0);
   // Leave the repeat loop when the held button drops or the other one joins.
   assign abort  = dir ? (!deb_up || deb_dn) : (!deb_dn || deb_up);
   assign lim    = (state == DELAY) ? TW'(RPT_DLY - 1) : TW'(RPT_PER - 1);

   // Load edge detection, repeat FSM and registered pulse outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         dir     <= 1'b0;
         timer   <= '0;
         ld_prev <= 1'b0;
         incr    <= 1'b0;
         decr    <= 1'b0;
         ld      <= 1'b0;
         D       <= '0;
      end else begin
         incr    <= 1'b0;
         decr    <= 1'b0;
         ld      <= 1'b0;
         ld_prev <= deb_ld;
         if (deb_ld && !ld_prev) begin
            // Load wins over any up/down activity and restarts the FSM.
            ld    <= 1'b1;
            D     <= base_in;
            state <= IDLE;
            timer <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (deb_up ^ deb_dn) begin
                     dir   <= deb_up;
                     timer <= '0;
                     state <= DELAY;
                     incr  <= deb_up && !sat_hi;
                     decr  <= deb_dn && !sat_lo;
                  end
               end
               DELAY, REPEAT: begin
                  if (abort) begin
                     state <= IDLE;
                  end else if (timer == lim) begin
                     timer <= '0;
                     state <= REPEAT;
                     incr  <= dir && !sat_hi;
                     decr  <= !dir && !sat_lo;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
